// File: rtl/frame_pkg.sv
// frame_pkg: framing markers, FSM encoding and helpers
// shared by the frame stream to AXIS path.
package frame_pkg;

  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;

  localparam logic [63:0] FORCED_CLOSE =
    {FOOTER_ID, 8'hFF, 48'h0};

  typedef enum logic [1:0] {
    HUNT,
    BODY,
    FLUSH
  } state_t;

  function automatic logic is_header(
    input logic [7:0] tag,
    input logic [7:0] id = HEADER_ID
  );
    return tag == id;
  endfunction

  function automatic logic is_footer(
    input logic [7:0] tag,
    input logic [7:0] id = FOOTER_ID
  );
    return tag == id;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry ready/valid buffer whose
// inReady/outValid come straight from the occupancy register.
module axis_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign inReady  = count != 2'd2;
  assign outValid = count != 2'd0;
  assign outData  = head;
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      // push with pop only happens at count==1
      if (push && pop) begin
        head <= inData;
      end else if (pop) begin
        head <= tail;
      end else if (push) begin
        if (count == 2'd0) head <= inData;
        else               tail <= inData;
      end
    end
  end

endmodule

// File: rtl/frame_axis_sender.sv
// frame_axis_sender: re-emits header/data/footer words as
// AXI4-Stream, closing or dropping malformed frames.
module frame_axis_sender #(
  parameter int         DATA_WIDTH       = 64,
  parameter int         MAX_FRAME_LENGTH = 200,
  parameter logic [7:0] HEADER_ID        = frame_pkg::HEADER_ID,
  parameter logic [7:0] FOOTER_ID        = frame_pkg::FOOTER_ID,
  parameter int         CNT_WIDTH        = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  iVALID,
  output logic                  oREADY,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [CNT_WIDTH-1:0]  DROP_CNT,
  output logic                  ERR_FLAG
);
  import frame_pkg::*;

  localparam int LEN_W = $clog2(MAX_FRAME_LENGTH + 1);
  localparam int SW    = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] CLOSE_WORD =
    {FOOTER_ID, FORCED_CLOSE[55:48],
     {(DATA_WIDTH-16){1'b0}}};

  state_t                 state;
  state_t                 nextState;
  logic [LEN_W-1:0]       len;
  logic                   rdyEn;
  logic                   pendValid;
  logic [DATA_WIDTH-1:0]  pendData;
  logic                   skidReady;
  logic [SW-1:0]          skidOut;
  logic [7:0]             tag;
  logic                   acc;
  logic                   isHdr;
  logic                   isFtr;
  logic                   lenOk;
  logic                   pushWord;
  logic [SW-1:0]          pushData;
  logic                   lenClr;
  logic                   lenInc;
  logic                   frameInc;
  logic                   dropInc;
  logic                   pendSet;

  assign tag    = DIN[DATA_WIDTH-1 -: 8];
  assign isHdr  = is_header(tag, HEADER_ID);
  assign isFtr  = is_footer(tag, FOOTER_ID);
  assign lenOk  = len < LEN_W'(MAX_FRAME_LENGTH);
  // a queued header after a forced close blocks new input
  assign oREADY = rdyEn && skidReady && !pendValid;
  assign acc    = iVALID && oREADY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= HUNT;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (acc) begin
      unique case (state)
        HUNT: if (isHdr) nextState = BODY;
        BODY: begin
          if (isFtr)               nextState = HUNT;
          else if (!isHdr && !lenOk) nextState = FLUSH;
        end
        FLUSH: begin
          if (isHdr)      nextState = BODY;
          else if (isFtr) nextState = HUNT;
        end
        default: nextState = HUNT;
      endcase
    end
  end

  always_comb begin
    pushWord = 1'b0;
    pushData = {1'b0, DIN};
    lenClr   = 1'b0;
    lenInc   = 1'b0;
    frameInc = 1'b0;
    dropInc  = 1'b0;
    pendSet  = 1'b0;
    if (pendValid) begin
      pushWord = 1'b1;
      pushData = {1'b0, pendData};
    end else if (acc) begin
      unique case (state)
        HUNT: begin
          pushWord = isHdr;
          lenClr   = isHdr;
        end
        BODY: begin
          pushWord = 1'b1;
          if (isHdr) begin
            pushData = {1'b1, CLOSE_WORD};
            dropInc  = 1'b1;
            pendSet  = 1'b1;
            lenClr   = 1'b1;
          end else if (isFtr) begin
            pushData = {1'b1, DIN};
            frameInc = 1'b1;
          end else if (lenOk) begin
            lenInc   = 1'b1;
          end else begin
            pushData = {1'b1, CLOSE_WORD};
            dropInc  = 1'b1;
          end
        end
        FLUSH: begin
          pushWord = isHdr;
          lenClr   = isHdr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rdyEn     <= 1'b0;
      pendValid <= 1'b0;
      pendData  <= '0;
      len       <= '0;
      FRAME_CNT <= '0;
      DROP_CNT  <= '0;
      ERR_FLAG  <= 1'b0;
    end else begin
      rdyEn <= 1'b1;
      if (pendSet)                     pendValid <= 1'b1;
      else if (pendValid && skidReady) pendValid <= 1'b0;
      if (pendSet) pendData <= DIN;
      if (lenClr)      len <= '0;
      else if (lenInc) len <= len + 1'b1;
      FRAME_CNT <= FRAME_CNT + CNT_WIDTH'(frameInc);
      DROP_CNT  <= DROP_CNT + CNT_WIDTH'(dropInc);
      ERR_FLAG  <= ERR_FLAG | dropInc;
    end
  end

  axis_skid_buffer #(
    .WIDTH(SW)
  ) u_skid (
    .clk     (CLK),
    .rst_n   (RESETN),
    .inValid (pushWord),
    .inReady (skidReady),
    .inData  (pushData),
    .outValid(M_AXIS_TVALID),
    .outReady(M_AXIS_TREADY),
    .outData (skidOut)
  );

  assign M_AXIS_TDATA = skidOut[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST = skidOut[DATA_WIDTH];

endmodule

// File: tb/tb_frame_axis_sender.sv
// tb_frame_axis_sender: random and directed frames checked
// against a frame-level model of the sender.
module tb_frame_axis_sender;

  localparam int MAXL = 200;
  localparam logic [63:0] CLOSE = 64'h55FF_0000_0000_0000;
  localparam logic [63:0] JUNK  = 64'h0123_4567_89AB_CDEF;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        iVALID = 1'b0;
  logic        oREADY;
  logic [63:0] DIN = '0;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b1;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic [15:0] FRAME_CNT;
  logic [15:0] DROP_CNT;
  logic        ERR_FLAG;

  int          nChecks = 0;
  int          nFail = 0;
  logic [64:0] q[$];
  int          mState;
  int          mLen;
  int          mFrame;
  int          mDrop;
  bit          mErr;
  int          beatCnt = 0;
  logic [64:0] lastBeat;
  bit          lastAcc;
  bit          prevStall;
  logic [64:0] prevBeat;
  bit          sTvalid;
  bit          sOready;
  logic [63:0] sTdata;
  int          readyMode = 0;

  always #5 CLK = ~CLK;

  frame_axis_sender dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .iVALID       (iVALID),
    .oREADY       (oREADY),
    .DIN          (DIN),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .FRAME_CNT    (FRAME_CNT),
    .DROP_CNT     (DROP_CNT),
    .ERR_FLAG     (ERR_FLAG)
  );

  task automatic chk(input string name,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Frame rules applied to each accepted upstream word.
  task automatic modelAccept(input logic [63:0] w);
    logic [7:0] t;
    t = w[63:56];
    if (mState == 0) begin
      if (t == 8'hAA) begin
        q.push_back({1'b0, w});
        mLen = 0;
        mState = 1;
      end
    end else if (mState == 1) begin
      if (t == 8'hAA) begin
        q.push_back({1'b1, CLOSE});
        q.push_back({1'b0, w});
        mDrop++;
        mErr = 1;
        mLen = 0;
      end else if (t == 8'h55) begin
        q.push_back({1'b1, w});
        mFrame++;
        mState = 0;
      end else if (mLen < MAXL) begin
        q.push_back({1'b0, w});
        mLen++;
      end else begin
        q.push_back({1'b1, CLOSE});
        mDrop++;
        mErr = 1;
        mState = 2;
      end
    end else begin
      if (t == 8'hAA) begin
        q.push_back({1'b0, w});
        mLen = 0;
        mState = 1;
      end else if (t == 8'h55) begin
        mState = 0;
      end
    end
  endtask

  task automatic monitor();
    sTvalid = M_AXIS_TVALID;
    sTdata  = M_AXIS_TDATA;
    sOready = oREADY;
    lastAcc = 1'b0;
    if (!RESETN) begin
      chk("rst_tvalid", 65'(M_AXIS_TVALID), 65'(0));
      chk("rst_tlast", 65'(M_AXIS_TLAST), 65'(0));
      chk("rst_tdata", 65'(M_AXIS_TDATA), 65'(0));
      chk("rst_oready", 65'(oREADY), 65'(0));
      chk("rst_frame", 65'(FRAME_CNT), 65'(0));
      chk("rst_drop", 65'(DROP_CNT), 65'(0));
      chk("rst_err", 65'(ERR_FLAG), 65'(0));
      q.delete();
      mState = 0;
      mLen = 0;
      mFrame = 0;
      mDrop = 0;
      mErr = 0;
      prevStall = 0;
      return;
    end
    chk("frame_cnt", 65'(FRAME_CNT), 65'(mFrame[15:0]));
    chk("drop_cnt", 65'(DROP_CNT), 65'(mDrop[15:0]));
    chk("err_flag", 65'(ERR_FLAG), 65'(mErr));
    if (prevStall) begin
      chk("hold_valid", 65'(M_AXIS_TVALID), 65'(1));
      chk("hold_beat", {M_AXIS_TLAST, M_AXIS_TDATA},
          prevBeat);
    end
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      lastBeat = {M_AXIS_TLAST, M_AXIS_TDATA};
      beatCnt++;
      if (q.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL beat_unexpected actual=%h required=none",
                 lastBeat);
      end else begin
        chk("beat", lastBeat, q.pop_front());
      end
    end
    if (iVALID && oREADY) begin
      lastAcc = 1'b1;
      modelAccept(DIN);
    end
    prevStall = M_AXIS_TVALID && !M_AXIS_TREADY;
    prevBeat  = {M_AXIS_TLAST, M_AXIS_TDATA};
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    case (readyMode)
      0: M_AXIS_TREADY = 1'b1;
      1: M_AXIS_TREADY = !M_AXIS_TREADY;
      2: M_AXIS_TREADY = 1'($urandom_range(0, 1));
      default: M_AXIS_TREADY = 1'b0;
    endcase
  endtask

  task automatic doReset();
    RESETN = 1'b0;
    iVALID = 1'b0;
    repeat (2) tick();
    RESETN = 1'b1;
    tick();
    chk("rdy_first_cycle", 65'(sOready), 65'(0));
    tick();
    chk("rdy_second_cycle", 65'(sOready), 65'(1));
  endtask

  task automatic sendWord(input logic [63:0] w,
                          input int gapMax);
    int n;
    repeat ($urandom_range(0, gapMax)) tick();
    iVALID = 1'b1;
    DIN = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!lastAcc && n < 1000);
    if (!lastAcc) chk("accept_timeout", 65'(lastAcc), 65'(1));
    iVALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((q.size() != 0 || sTvalid) && n < 3000);
    chk("drain_empty", 65'(q.size()), 65'(0));
  endtask

  function automatic logic [63:0] hdr(input int k);
    return {8'hAA, 56'(k)};
  endfunction

  function automatic logic [63:0] ftr(input int k);
    return {8'h55, 56'(k)};
  endfunction

  function automatic logic [63:0] dat();
    return {4'h0, 28'($urandom), 32'($urandom)};
  endfunction

  task automatic sendFrame(input int k, input int n,
                           input int gap);
    sendWord(hdr(k), gap);
    for (int i = 0; i < n; i++) sendWord(dat(), gap);
    sendWord(ftr(k), gap);
  endtask

  initial begin
    int base;
    int r;
    int len;
    @(posedge CLK);
    #1;

    // 1: plain frame, latency and TLAST placement
    doReset();
    readyMode = 0;
    base = beatCnt;
    sendWord(hdr(1), 0);
    tick();
    chk("lat_tvalid", 65'(sTvalid), 65'(1));
    chk("lat_tdata", 65'(sTdata), 65'(hdr(1)));
    for (int i = 0; i < 3; i++) sendWord(dat(), 0);
    sendWord(ftr(1), 0);
    drain();
    chk("t1_beats", 65'(beatCnt - base), 65'(5));
    chk("t1_last", lastBeat, {1'b1, ftr(1)});
    chk("t1_frames", 65'(FRAME_CNT), 65'(1));

    // 2: toggling TREADY with input gaps
    doReset();
    readyMode = 1;
    base = beatCnt;
    sendFrame(2, 3, 3);
    readyMode = 0;
    drain();
    chk("t2_beats", 65'(beatCnt - base), 65'(5));
    chk("t2_frames", 65'(FRAME_CNT), 65'(1));

    // 3: overflow by one data word
    doReset();
    base = beatCnt;
    sendFrame(3, MAXL + 1, 0);
    drain();
    chk("t3_beats", 65'(beatCnt - base), 65'(MAXL + 2));
    chk("t3_last", lastBeat, {1'b1, CLOSE});
    chk("t3_drops", 65'(DROP_CNT), 65'(1));
    chk("t3_err", 65'(ERR_FLAG), 65'(1));
    chk("t3_frames", 65'(FRAME_CNT), 65'(0));

    // 4: missing footer, random backpressure
    doReset();
    readyMode = 2;
    base = beatCnt;
    sendWord(hdr(4), 0);
    sendWord(dat(), 0);
    sendWord(dat(), 0);
    sendFrame(5, 1, 0);
    readyMode = 0;
    drain();
    chk("t4_beats", 65'(beatCnt - base), 65'(7));
    chk("t4_frames", 65'(FRAME_CNT), 65'(1));
    chk("t4_drops", 65'(DROP_CNT), 65'(1));

    // 5: garbage before first header
    doReset();
    base = beatCnt;
    for (int i = 0; i < 4; i++) sendWord(JUNK, 1);
    sendWord(ftr(9), 0);
    repeat (4) tick();
    chk("t5_quiet", 65'(beatCnt - base), 65'(0));
    chk("t5_drops", 65'(DROP_CNT), 65'(0));
    sendFrame(6, 1, 0);
    drain();
    chk("t5_beats", 65'(beatCnt - base), 65'(3));
    chk("t5_frames", 65'(FRAME_CNT), 65'(1));

    // 6: reset while a beat is stalled
    doReset();
    sendFrame(7, 1, 0);
    drain();
    readyMode = 3;
    M_AXIS_TREADY = 1'b0;
    sendWord(hdr(8), 0);
    sendWord(dat(), 0);
    tick();
    chk("t6_stalled", 65'(sTvalid), 65'(1));
    #3;
    RESETN = 1'b0;
    #1;
    chk("t6_tvalid", 65'(M_AXIS_TVALID), 65'(0));
    chk("t6_tlast", 65'(M_AXIS_TLAST), 65'(0));
    chk("t6_frame", 65'(FRAME_CNT), 65'(0));
    chk("t6_err", 65'(ERR_FLAG), 65'(0));
    @(posedge CLK);
    #1;
    readyMode = 0;
    doReset();
    base = beatCnt;
    sendFrame(9, 2, 0);
    drain();
    chk("t6_beats", 65'(beatCnt - base), 65'(4));
    chk("t6_frames", 65'(FRAME_CNT), 65'(1));

    // 7: random frames, markers and backpressure
    doReset();
    readyMode = 2;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) sendWord(JUNK, 1);
      sendWord(hdr(f), 1);
      if (r == 1) len = $urandom_range(MAXL - 2, MAXL + 3);
      else        len = $urandom_range(0, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 39) == 0) sendWord(hdr(f), 0);
        else                            sendWord(dat(), r == 1 ? 0 : 2);
      end
      if (r != 2) sendWord(ftr(f), 1);
    end
    sendWord(ftr(99), 0);
    readyMode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             nChecks, nFail);
    $finish;
  end

endmodule
